// File: rtl/dht11_responder_pkg.sv
// Shared definitions for the DHT11 single-wire responder and its host-side driver.
// Holds the FSM encoding and the bus timing constants, all in 1 us ticks.
package dht11_responder_pkg;

    typedef enum logic [3:0] {
        IDLE,
        HOST_LOW,
        RESP_DELAY,
        RESP_LOW,
        RESP_HIGH,
        BIT_LOW,
        BIT_HIGH,
        END_LOW,
        COOLDOWN
    } dht_state_t;

    localparam int               CNT_W      = 15;
    localparam logic [CNT_W-1:0] CNT_MAX    = 15'h7fff;
    localparam logic [CNT_W-1:0] CNT_ONE    = 15'd1;
    localparam logic [CNT_W-1:0] T_RESP_LOW  = 15'd80;
    localparam logic [CNT_W-1:0] T_RESP_HIGH = 15'd80;
    localparam logic [CNT_W-1:0] T_BIT_LOW   = 15'd50;
    localparam logic [CNT_W-1:0] T_BIT_ZERO  = 15'd26;
    localparam logic [CNT_W-1:0] T_BIT_ONE   = 15'd70;
    localparam logic [CNT_W-1:0] T_END_LOW   = 15'd50;
    localparam int               FRAME_BITS  = 40;

    function automatic logic drives_low(input dht_state_t s);
        return (s == RESP_LOW) || (s == BIT_LOW) || (s == END_LOW);
    endfunction

    function automatic logic [7:0] frame_checksum(input logic [7:0] a, input logic [7:0] b,
                                                  input logic [7:0] c, input logic [7:0] d);
        return 8'(a + b + c + d);
    endfunction

endpackage

// File: rtl/dht11_responder_sync_2ff.sv
// Two-flop synchronizer for the raw single-wire bus level; resets to the idle-high level.
module sync_2ff (
    input  logic clk,
    input  logic rst_debounced,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst_debounced) begin
        if (!rst_debounced) begin
            meta <= 1'b1;
            q    <= 1'b1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/dht11_responder.sv
// DHT11 sensor-side responder: detects a host start pulse, then drives a 40-bit
// humidity/temperature frame with checksum onto the open-drain single-wire bus.
//
// state      | meaning
// IDLE       | waiting for a bus falling edge while enabled
// HOST_LOW   | measuring host low pulse length
// RESP_DELAY | released, waiting before the response
// RESP_LOW   | response low (80 us)
// RESP_HIGH  | response high (80 us)
// BIT_LOW    | bit preamble low (50 us)
// BIT_HIGH   | bit value high (26 us '0', 70 us '1')
// END_LOW    | trailing low after the last bit
// COOLDOWN   | dead time, bus ignored
module dht11_responder
    import dht11_responder_pkg::*;
#(
    parameter int START_MIN_US  = 18000,
    parameter int RESP_DELAY_US = 30,
    parameter int COOLDOWN_US   = 1000
) (
    input  logic       clk,
    input  logic       rst_debounced,
    input  logic       tick_1us,
    input  logic       dat_in,
    output logic       dat_oe,
    input  logic       enable,
    input  logic [7:0] humid_int,
    input  logic [7:0] humid_dec,
    input  logic [7:0] temp_int,
    input  logic [7:0] temp_dec,
    output logic       busy,
    output logic       frame_done
);

    localparam logic [CNT_W-1:0] START_MIN    = CNT_W'(START_MIN_US);
    localparam logic [CNT_W-1:0] RESP_DELAY_T = CNT_W'(RESP_DELAY_US);
    localparam logic [CNT_W-1:0] COOLDOWN_T   = CNT_W'(COOLDOWN_US);
    localparam logic [5:0]       BITS_INIT    = 6'(FRAME_BITS);

    dht_state_t             state, state_nxt;
    logic [CNT_W-1:0]       cnt, cnt_nxt;
    logic [FRAME_BITS-1:0]  shreg, shreg_nxt;
    logic [5:0]             bits_left, bits_nxt;
    logic                   bus_s, bus_prev, bus_fall, terminal, done_nxt;

    sync_2ff u_sync (
        .clk           (clk),
        .rst_debounced (rst_debounced),
        .d             (dat_in),
        .q             (bus_s)
    );

    assign bus_fall = bus_prev & ~bus_s;
    assign busy     = (state != IDLE) && (state != HOST_LOW);

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        shreg_nxt = shreg;
        bits_nxt  = bits_left;
        done_nxt  = 1'b0;
        terminal  = tick_1us && (cnt == CNT_ONE);

        // Timed phases share one down-counter; a phase lasts exactly its load value in ticks.
        if (busy && tick_1us && (cnt != '0))
            cnt_nxt = cnt - CNT_ONE;

        case (state)
            IDLE: begin
                if (bus_fall && enable) begin
                    state_nxt = HOST_LOW;
                    cnt_nxt   = '0;
                end
            end
            HOST_LOW: begin
                if (bus_s) begin
                    cnt_nxt = '0;
                    if (cnt >= START_MIN) begin
                        state_nxt = RESP_DELAY;
                        cnt_nxt   = RESP_DELAY_T;
                        shreg_nxt = {humid_int, humid_dec, temp_int, temp_dec,
                                     frame_checksum(humid_int, humid_dec, temp_int, temp_dec)};
                        bits_nxt  = BITS_INIT;
                    end else begin
                        state_nxt = IDLE;
                    end
                end else if (tick_1us && (cnt != CNT_MAX)) begin
                    cnt_nxt = cnt + CNT_ONE;
                end
            end
            RESP_DELAY: if (terminal) begin
                state_nxt = RESP_LOW;
                cnt_nxt   = T_RESP_LOW;
            end
            RESP_LOW: if (terminal) begin
                state_nxt = RESP_HIGH;
                cnt_nxt   = T_RESP_HIGH;
            end
            RESP_HIGH: if (terminal) begin
                state_nxt = BIT_LOW;
                cnt_nxt   = T_BIT_LOW;
            end
            BIT_LOW: if (terminal) begin
                state_nxt = BIT_HIGH;
                cnt_nxt   = shreg[FRAME_BITS-1] ? T_BIT_ONE : T_BIT_ZERO;
            end
            BIT_HIGH: if (terminal) begin
                shreg_nxt = {shreg[FRAME_BITS-2:0], 1'b0};
                bits_nxt  = bits_left - 6'd1;
                if (bits_left == 6'd1) begin
                    state_nxt = END_LOW;
                    cnt_nxt   = T_END_LOW;
                end else begin
                    state_nxt = BIT_LOW;
                    cnt_nxt   = T_BIT_LOW;
                end
            end
            END_LOW: if (terminal) begin
                state_nxt = COOLDOWN;
                cnt_nxt   = COOLDOWN_T;
                done_nxt  = 1'b1;
            end
            COOLDOWN: if (terminal) begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_debounced) begin
        if (!rst_debounced) begin
            state      <= IDLE;
            cnt        <= '0;
            shreg      <= '0;
            bits_left  <= '0;
            bus_prev   <= 1'b1;
            dat_oe     <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            shreg      <= shreg_nxt;
            bits_left  <= bits_nxt;
            bus_prev   <= bus_s;
            dat_oe     <= drives_low(state_nxt);
            frame_done <= done_nxt;
        end
    end

endmodule
